// File: rtl/fp_add_arbiter.sv
// fp_add_arbiter: round-robin arbiter sharing one multi-cycle FP adder between two requesters.
// Define FP_ADD_ARB_TIMEOUT_EN to enable the WAIT-state watchdog (TIMEOUT_CYCLES).
module fp_add_arbiter #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req0_valid,
  input  logic        req1_valid,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic        req0_ready,
  output logic        req1_ready,
  output logic        rsp0_valid,
  output logic        rsp1_valid,
  output logic [31:0] rsp_data,
  output logic        add_input_valid,
  output logic [31:0] add_in_a,
  output logic [31:0] add_in_b,
  input  logic [31:0] add_data_out,
  input  logic        add_output_valid,
  output logic        busy,
  output logic        timeout_err
);
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;
  state_t      r_state, w_next;
  logic        r_last, r_id, r_rsp0, r_rsp1;
  logic [31:0] r_a, r_b, r_rsp_data;
  logic        w_g0, w_g1, w_done, w_to;
  // r_last = 1 means req1 was granted last, so req0 has priority on a tie
  assign w_g0 = (r_state == S_IDLE) && req0_valid && (!req1_valid || r_last);
  assign w_g1 = (r_state == S_IDLE) && req1_valid && !w_g0;
  assign w_done = (r_state == S_WAIT) && (add_output_valid || w_to);
  assign req0_ready = w_g0;
  assign req1_ready = w_g1;
  assign add_input_valid = (r_state == S_ISSUE);
  assign add_in_a = r_a;
  assign add_in_b = r_b;
  assign rsp0_valid = r_rsp0;
  assign rsp1_valid = r_rsp1;
  assign rsp_data = r_rsp_data;
  assign busy = (r_state != S_IDLE);
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = (w_g0 || w_g1) ? S_ISSUE : S_IDLE;
      S_ISSUE: w_next = S_WAIT;
      S_WAIT:  w_next = w_done ? S_IDLE : S_WAIT;
      default: w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_last     <= 1'b1;
      r_id       <= 1'b0;
      r_a        <= 32'h0;
      r_b        <= 32'h0;
      r_rsp_data <= 32'h0;
      r_rsp0     <= 1'b0;
      r_rsp1     <= 1'b0;
    end else begin
      r_state <= w_next;
      r_rsp0  <= w_done && !r_id;
      r_rsp1  <= w_done && r_id;
      if (w_g0 || w_g1) begin
        r_a    <= w_g1 ? req1_a : req0_a;
        r_b    <= w_g1 ? req1_b : req0_b;
        r_id   <= w_g1;
        r_last <= w_g1;
      end
      if (w_done) r_rsp_data <= add_output_valid ? add_data_out : 32'h7FC00000;
    end
  end
`ifdef FP_ADD_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CW-1:0] r_cnt;
  logic          r_to;
  assign w_to = (r_state == S_WAIT) && !add_output_valid && (r_cnt == CW'(TIMEOUT_CYCLES - 1));
  assign timeout_err = r_to;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
      r_to  <= 1'b0;
    end else begin
      r_cnt <= (r_state == S_WAIT) ? r_cnt + CW'(1) : '0;
      r_to  <= w_to;
    end
  end
`else
  logic w_unused;
  assign w_unused = |TIMEOUT_CYCLES;
  assign w_to = 1'b0;
  assign timeout_err = 1'b0;
`endif
endmodule

// File: tb/tb_fp_add_arbiter.sv
// tb_fp_add_arbiter: directed-vector bench for fp_add_arbiter with a 2-cycle stand-in adder.
// Covers the FP_ADD_ARB_TIMEOUT_EN build and the default build.
module tb_fp_add_arbiter;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid;
  logic [31:0] rsp_data, add_in_a, add_in_b;
  logic        add_input_valid, busy, timeout_err;
  logic [31:0] add_data_out = '0;
  logic        add_output_valid = 1'b0;
  int n_vec = 0, n_err = 0;

  fp_add_arbiter #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid), .rsp_data(rsp_data),
    .add_input_valid(add_input_valid), .add_in_a(add_in_a), .add_in_b(add_in_b),
    .add_data_out(add_data_out), .add_output_valid(add_output_valid),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Stand-in adder: table of exact sums, responds 2 cycles after accepting, not reset by reset_n
  logic   model_en = 1'b1, m_pend = 1'b0;
  logic   m_cnt = 1'b0;
  function automatic logic [31:0] model_sum(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      {32'h3F800000, 32'h40000000}: return 32'h40400000;
      {32'h3F800000, 32'h3F800000}: return 32'h40000000;
      {32'h40000000, 32'h40000000}: return 32'h40800000;
      {32'h3F000000, 32'h3F000000}: return 32'h3F800000;
      default:                      return a ^ b;
    endcase
  endfunction
  always @(posedge clk) begin
    add_output_valid <= 1'b0;
    if (add_input_valid && model_en) begin
      m_pend       <= 1'b1;
      m_cnt        <= 1'b1;
      add_data_out <= model_sum(add_in_a, add_in_b);
    end else if (m_pend) begin
      if (m_cnt == 1'b0) begin
        m_pend           <= 1'b0;
        add_output_valid <= 1'b1;
      end else m_cnt <= 1'b0;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic wait_rsp(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      #1;
      cyc++;
    end while (!(rsp0_valid || rsp1_valid) && cyc < 200);
  endtask

  task automatic test_reset();
    @(negedge clk);
    #1;
    n_vec++;
    if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, add_input_valid, busy, timeout_err} !== 7'b0) begin
      n_err++;
      $display("FAIL reset_ctrl: got %b want 0000000", {req0_ready, req1_ready, rsp0_valid, rsp1_valid, add_input_valid, busy, timeout_err});
    end
    n_vec++;
    if (add_in_a !== 32'h0 || add_in_b !== 32'h0 || rsp_data !== 32'h0) begin
      n_err++;
      $display("FAIL reset_data: a=%h b=%h rsp=%h want all 0", add_in_a, add_in_b, rsp_data);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_single();
    int cyc, pulses;
    @(negedge clk);
    req0_valid = 1'b1;
    req0_a = 32'h3F800000;
    req0_b = 32'h40000000;
    #1;
    n_vec++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      n_err++;
      $display("FAIL single_grant: rdy0=%b rdy1=%b want 1 0", req0_ready, req1_ready);
    end
    @(negedge clk);
    req0_valid = 1'b0;
    #1;
    n_vec++;
    if (add_input_valid !== 1'b1 || add_in_a !== 32'h3F800000 || add_in_b !== 32'h40000000 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL single_issue: iv=%b a=%h b=%h busy=%b want 1 3f800000 40000000 1", add_input_valid, add_in_a, add_in_b, busy);
    end
    pulses = 1;
    cyc = 0;
    while (!(rsp0_valid || rsp1_valid) && cyc < 100) begin
      @(negedge clk);
      #1;
      cyc++;
      if (add_input_valid) pulses++;
    end
    n_vec++;
    if (pulses !== 1) begin
      n_err++;
      $display("FAIL single_pulses: got %0d want 1", pulses);
    end
    n_vec++;
    if (rsp0_valid !== 1'b1 || rsp1_valid !== 1'b0 || rsp_data !== 32'h40400000 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL single_rsp: r0=%b r1=%b data=%h busy=%b want 1 0 40400000 0", rsp0_valid, rsp1_valid, rsp_data, busy);
    end
    @(negedge clk);
    #1;
    n_vec++;
    if (rsp0_valid !== 1'b0 || rsp_data !== 32'h40400000) begin
      n_err++;
      $display("FAIL single_hold: r0=%b data=%h want 0 40400000", rsp0_valid, rsp_data);
    end
  endtask

  task automatic test_both();
    int cyc;
    do_reset();
    @(negedge clk);
    req0_valid = 1'b1; req0_a = 32'h3F800000; req0_b = 32'h3F800000;
    req1_valid = 1'b1; req1_a = 32'h40000000; req1_b = 32'h40000000;
    #1;
    n_vec++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      n_err++;
      $display("FAIL both_first: rdy0=%b rdy1=%b want 1 0", req0_ready, req1_ready);
    end
    @(negedge clk);
    req0_valid = 1'b0;
    #1;
    n_vec++;
    if (req1_ready !== 1'b0) begin
      n_err++;
      $display("FAIL both_busy_rdy: rdy1=%b want 0", req1_ready);
    end
    wait_rsp(cyc);
    n_vec++;
    if (rsp0_valid !== 1'b1 || rsp1_valid !== 1'b0 || rsp_data !== 32'h40000000 || req1_ready !== 1'b1) begin
      n_err++;
      $display("FAIL both_rsp0: r0=%b r1=%b data=%h rdy1=%b want 1 0 40000000 1", rsp0_valid, rsp1_valid, rsp_data, req1_ready);
    end
    @(negedge clk);
    req1_valid = 1'b0;
    wait_rsp(cyc);
    n_vec++;
    if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b1 || rsp_data !== 32'h40800000) begin
      n_err++;
      $display("FAIL both_rsp1: r0=%b r1=%b data=%h want 0 1 40800000", rsp0_valid, rsp1_valid, rsp_data);
    end
  endtask

  task automatic test_back_to_back();
    int g = 0, r = 0, cyc = 0;
    logic pend_id = 1'b0;
    logic [31:0] exp_data;
    req0_a = 32'h3F800000; req0_b = 32'h3F800000;
    req1_a = 32'h3F000000; req1_b = 32'h3F000000;
    @(negedge clk);
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    while (r < 6 && cyc < 400) begin
      if (cyc > 0) @(negedge clk);
      if (g == 6) begin
        req0_valid = 1'b0;
        req1_valid = 1'b0;
      end
      #1;
      cyc++;
      if (rsp0_valid || rsp1_valid) begin
        exp_data = pend_id ? 32'h3F800000 : 32'h40000000;
        n_vec++;
        if (rsp1_valid !== pend_id || rsp0_valid === rsp1_valid || rsp_data !== exp_data) begin
          n_err++;
          $display("FAIL b2b_rsp%0d: r0=%b r1=%b data=%h want id %0d data %h", r, rsp0_valid, rsp1_valid, rsp_data, pend_id, exp_data);
        end
        r++;
      end
      n_vec++;
      if (busy !== (g > r)) begin
        n_err++;
        $display("FAIL b2b_busy: got %b want %b (grants %0d rsps %0d)", busy, (g > r), g, r);
      end
      if (req0_ready || req1_ready) begin
        n_vec++;
        if ({req0_ready, req1_ready} !== ((g % 2 == 1) ? 2'b01 : 2'b10) || g != r) begin
          n_err++;
          $display("FAIL b2b_grant%0d: rdy=%b%b want %0d, outstanding %0d", g, req0_ready, req1_ready, g % 2, g - r);
        end
        pend_id = req1_ready;
        g++;
      end
    end
    n_vec++;
    if (g != 6 || r != 6) begin
      n_err++;
      $display("FAIL b2b_count: grants %0d rsps %0d want 6 6", g, r);
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    logic saw_ov = 1'b0, saw_bad = 1'b0;
    @(negedge clk);
    req0_valid = 1'b1; req0_a = 32'h40000000; req0_b = 32'h40000000;
    #1;
    n_vec++;
    if (req0_ready !== 1'b1) begin
      n_err++;
      $display("FAIL rmid_grant: rdy0=%b want 1", req0_ready);
    end
    @(negedge clk);
    req0_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    n_vec++;
    if (busy !== 1'b0 || add_in_a !== 32'h0 || add_in_b !== 32'h0 || rsp_data !== 32'h0 || rsp0_valid !== 1'b0) begin
      n_err++;
      $display("FAIL rmid_zero: busy=%b a=%h b=%h rsp=%h r0=%b want all 0", busy, add_in_a, add_in_b, rsp_data, rsp0_valid);
    end
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      saw_ov |= add_output_valid;
      saw_bad |= rsp0_valid | rsp1_valid | busy;
    end
    n_vec++;
    if (saw_ov !== 1'b1 || saw_bad !== 1'b0) begin
      n_err++;
      $display("FAIL rmid_late: late_ov=%b rsp_or_busy=%b want 1 0", saw_ov, saw_bad);
    end
    @(negedge clk);
    req0_valid = 1'b1; req0_a = 32'h3F800000; req0_b = 32'h3F800000;
    req1_valid = 1'b1;
    #1;
    n_vec++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      n_err++;
      $display("FAIL rmid_ptr: rdy0=%b rdy1=%b want 1 0", req0_ready, req1_ready);
    end
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    wait_rsp(cyc);
    n_vec++;
    if (rsp0_valid !== 1'b1 || rsp_data !== 32'h40000000) begin
      n_err++;
      $display("FAIL rmid_rsp: r0=%b data=%h want 1 40000000", rsp0_valid, rsp_data);
    end
  endtask

`ifdef FP_ADD_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int k = 0;
    model_en = 1'b0;
    @(negedge clk);
    req1_valid = 1'b1; req1_a = 32'h3F800000; req1_b = 32'h40000000;
    #1;
    n_vec++;
    if (req1_ready !== 1'b1) begin
      n_err++;
      $display("FAIL to_grant: rdy1=%b want 1", req1_ready);
    end
    do begin
      @(negedge clk);
      req1_valid = 1'b0;
      #1;
      k++;
    end while (!(rsp0_valid || rsp1_valid) && k < 40);
    n_vec++;
    if (k != 18 || rsp1_valid !== 1'b1 || rsp0_valid !== 1'b0 || timeout_err !== 1'b1 || rsp_data !== 32'h7FC00000) begin
      n_err++;
      $display("FAIL to_abort: cycle %0d r1=%b r0=%b err=%b data=%h want 18 1 0 1 7fc00000", k, rsp1_valid, rsp0_valid, timeout_err, rsp_data);
    end
    @(negedge clk);
    #1;
    n_vec++;
    if (timeout_err !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL to_after: err=%b busy=%b want 0 0", timeout_err, busy);
    end
    model_en = 1'b1;
  endtask
`else
  task automatic test_no_timeout();
    logic bad = 1'b0;
    model_en = 1'b0;
    @(negedge clk);
    req1_valid = 1'b1; req1_a = 32'h3F800000; req1_b = 32'h40000000;
    #1;
    n_vec++;
    if (req1_ready !== 1'b1) begin
      n_err++;
      $display("FAIL nto_grant: rdy1=%b want 1", req1_ready);
    end
    @(negedge clk);
    req1_valid = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      #1;
      bad |= !busy | rsp0_valid | rsp1_valid | timeout_err;
    end
    n_vec++;
    if (bad !== 1'b0) begin
      n_err++;
      $display("FAIL nto_hang: busy dropped or response seen=%b want 0", bad);
    end
    model_en = 1'b1;
    do_reset();
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_both();
    test_back_to_back();
    test_reset_mid();
`ifdef FP_ADD_ARB_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
